ibuf_loader: RTL and testbench

Input fetch stage that sits directly upstream of the input buffer (IBUF). On `start` it reads `num_words` consecutive 32-bit words from on-chip input memory, which has fixed 1-cycle read latency. It stages the words in a small credit-managed FIFO and emits them one per cycle as `IBUF_wr_en`/`IBUF_data_in`, honouring a downstream `stall`. It also counts emitted zero words for zero-skip statistics.

---
 rtl/ibuf_loader.sv | 105 ++++++++++
 tb/tb_ibuf_loader.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ibuf_loader.sv
// ibuf_loader: fetches num_words from 1-cycle-latency memory into a credit-managed FIFO
// and streams them to the IBUF one word per cycle under downstream stall.
module ibuf_loader #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int NUM_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [NUM_W-1:0]  num_words,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              stall,
    output logic              IBUF_wr_en,
    output logic [DATA_W-1:0] IBUF_data_in,
    output logic              busy,
    output logic              done,
    output logic [NUM_W-1:0]  zero_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [NUM_W-1:0]  num_q, issued_q, zero_q;
    logic              out_q, wr_en_q;
    logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [DATA_W-1:0] data_q, head;
    logic              accept, issue, pop;

    // A read is only issued when the FIFO is guaranteed room for its return data.
    assign accept = state_q == IDLE && start;
    assign issue  = state_q == FETCH && issued_q < num_q && count_q + CW'(out_q) < CW'(FIFO_DEPTH);
    assign pop    = count_q != '0 && !stall;
    assign head   = fifo_q[rd_ptr_q];

    assign mem_rd_en    = issue;
    assign mem_addr     = issue ? base_q + ADDR_W'(issued_q) : '0;
    assign IBUF_wr_en   = wr_en_q;
    assign IBUF_data_in = data_q;
    assign busy         = state_q == FETCH || state_q == DRAIN;
    assign done         = state_q == DONE;
    assign zero_count   = zero_q;

    // Leave DRAIN on the cycle of the final pop so done lines up with the last IBUF write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = num_words == '0 ? DONE : FETCH;
            FETCH:   if (issue && issued_q + NUM_W'(1) == num_q) state_d = DRAIN;
            DRAIN:   if (!out_q && count_q == CW'(pop)) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            base_q   <= '0;
            num_q    <= '0;
            issued_q <= '0;
            zero_q   <= '0;
            out_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wr_en_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= issue;
            count_q <= count_q + CW'(out_q) - CW'(pop);
            wr_en_q <= pop;
            if (out_q) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (pop) data_q <= head;
            if (accept) begin
                base_q   <= base_addr;
                num_q    <= num_words;
                issued_q <= '0;
                zero_q   <= '0;
            end else begin
                if (issue) issued_q <= issued_q + NUM_W'(1);
                if (pop && head == '0 && !(&zero_q)) zero_q <= zero_q + NUM_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (out_q) fifo_q[wr_ptr_q] <= mem_rd_data;
    end

    fifo_no_overflow_a: assert property (@(posedge clk) disable iff (!nRST)
        !(out_q && !pop && count_q == CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_ibuf_loader.sv
// tb_ibuf_loader: directed vector table plus hand sequences for reset and ignored start.
module tb_ibuf_loader;
    logic        clk = 1'b0;
    logic        nRST, start, stall;
    logic [15:0] base_addr, num_words, mem_addr, zero_count;
    logic        mem_rd_en, IBUF_wr_en, busy, done;
    logic [31:0] mem_rd_data, IBUF_data_in;

    ibuf_loader dut (
        .clk(clk), .nRST(nRST), .start(start), .base_addr(base_addr), .num_words(num_words),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .stall(stall),
        .IBUF_wr_en(IBUF_wr_en), .IBUF_data_in(IBUF_data_in), .busy(busy), .done(done),
        .zero_count(zero_count)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_arr [0:65535];
    always @(posedge clk) mem_rd_data <= mem_rd_en ? mem_arr[mem_addr] : 32'h0;

    typedef struct {
        logic [15:0] base;
        logic [15:0] num;
        int          slo, shi;
        int          exp_done, exp_first_wr;
        logic [31:0] exp_first, exp_last;
        logic [15:0] exp_zero;
        int          exp_reads12;
    } vec_t;

    vec_t vecs [6];
    int nvec = 0, nmis = 0;
    int r_done, r_first_wr, r_nrecv, r_reads, r_reads12, r_addr_err, r_data_err, r_done_cnt, r_busy;
    logic [31:0] r_first, r_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        nvec++;
        if (act !== exp_v) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'h0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, "_wr_en"}, 32'(IBUF_wr_en), 32'h0);
        chk({tag, "_data"}, IBUF_data_in, 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_zero"}, 32'(zero_count), 32'h0);
    endtask

    // Start a transfer in cycle T=0 and observe cycles T+k at the falling edge until one past done.
    task automatic run(input logic [15:0] b, input logic [15:0] n, input int slo, input int shi, input int rs_k);
        logic [15:0] idx;
        r_done = -1; r_first_wr = -1; r_nrecv = 0; r_reads = 0; r_reads12 = -1;
        r_addr_err = 0; r_data_err = 0; r_done_cnt = 0; r_busy = 0; r_first = 0; r_last = 0;
        @(negedge clk);
        base_addr = b; num_words = n; start = 1'b1; stall = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            start = k == rs_k;
            if (k == rs_k) begin base_addr = 16'h0900; num_words = 16'd2; end
            stall = k >= slo && k <= shi;
            if (mem_rd_en) begin
                if (mem_addr !== b + 16'(r_reads)) r_addr_err++;
                r_reads++;
            end
            if (k == 12) r_reads12 = r_reads;
            if (IBUF_wr_en) begin
                if (r_first_wr < 0) begin r_first_wr = k; r_first = IBUF_data_in; end
                r_last = IBUF_data_in;
                idx = b + 16'(r_nrecv);
                if (IBUF_data_in !== mem_arr[idx]) r_data_err++;
                r_nrecv++;
            end
            if (done) begin
                if (r_done < 0) r_done = k;
                r_done_cnt++;
            end
            if (busy) r_busy = 1;
            if (r_done >= 0 && k > r_done) break;
        end
        start = 1'b0; stall = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem_arr[a] = 32'(a) + 32'd1;
        mem_arr[16'h0300] = 32'd0; mem_arr[16'h0301] = 32'd7; mem_arr[16'h0302] = 32'd0;
        mem_arr[16'h0303] = 32'd0; mem_arr[16'h0304] = 32'd9; mem_arr[16'h0050] = 32'd0;
        vecs[0] = '{16'h0100, 16'd4, 0, -1,  7,  4, 32'h101,   32'h104,   16'd0, -1};
        vecs[1] = '{16'h2000, 16'd8, 2, 12, 21, 14, 32'h2001,  32'h2008,  16'd0,  4};
        vecs[2] = '{16'h0300, 16'd5, 0, -1,  8,  4, 32'h0,     32'h9,     16'd3, -1};
        vecs[3] = '{16'h0000, 16'd0, 0, -1,  1, -1, 32'h0,     32'h0,     16'd0, -1};
        vecs[4] = '{16'hFFFE, 16'd4, 0, -1,  7,  4, 32'hFFFF,  32'h2,     16'd0, -1};
        vecs[5] = '{16'h0050, 16'd1, 0, -1,  4,  4, 32'h0,     32'h0,     16'd1, -1};
        nRST = 1'b0; start = 1'b0; stall = 1'b0; base_addr = '0; num_words = '0; mem_rd_data = '0;
        @(negedge clk);
        chk_idle_outputs("por");
        nRST = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run(vecs[i].base, vecs[i].num, vecs[i].slo, vecs[i].shi, -1);
            chk($sformatf("v%0d_done_cyc", i), r_done, vecs[i].exp_done);
            chk($sformatf("v%0d_done_cnt", i), r_done_cnt, 1);
            chk($sformatf("v%0d_first_wr", i), r_first_wr, vecs[i].exp_first_wr);
            chk($sformatf("v%0d_nrecv", i), r_nrecv, 32'(vecs[i].num));
            chk($sformatf("v%0d_reads", i), r_reads, 32'(vecs[i].num));
            chk($sformatf("v%0d_addr_err", i), r_addr_err, 0);
            chk($sformatf("v%0d_data_err", i), r_data_err, 0);
            chk($sformatf("v%0d_zero", i), 32'(zero_count), 32'(vecs[i].exp_zero));
            chk($sformatf("v%0d_busy", i), r_busy, 32'(vecs[i].num != 0));
            if (vecs[i].num != 0) begin
                chk($sformatf("v%0d_first", i), r_first, vecs[i].exp_first);
                chk($sformatf("v%0d_last", i), r_last, vecs[i].exp_last);
            end
            if (vecs[i].exp_reads12 >= 0) chk($sformatf("v%0d_reads12", i), r_reads12, vecs[i].exp_reads12);
        end
        // start pulsed mid-FETCH with a different base/count must not be recaptured
        run(16'h0400, 16'd6, 0, -1, 3);
        chk("ign_done_cyc", r_done, 9);
        chk("ign_nrecv", r_nrecv, 6);
        chk("ign_reads", r_reads, 6);
        chk("ign_addr_err", r_addr_err, 0);
        chk("ign_data_err", r_data_err, 0);
        chk("ign_last", r_last, 32'h406);
        // reset mid-FETCH with two words staged and a read in flight
        @(negedge clk);
        base_addr = 16'h0700; num_words = 16'd8; start = 1'b1; stall = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            stall = k >= 2;
        end
        chk("pre_rst_rd_en", 32'(mem_rd_en), 32'h1);
        chk("pre_rst_addr", 32'(mem_addr), 32'h703);
        nRST = 1'b0;
        #1;
        chk_idle_outputs("rst");
        @(negedge clk);
        nRST = 1'b1; stall = 1'b0;
        run(16'h0010, 16'd3, 0, -1, -1);
        chk("post_done_cyc", r_done, 6);
        chk("post_nrecv", r_nrecv, 3);
        chk("post_first", r_first, 32'h11);
        chk("post_last", r_last, 32'h13);
        chk("post_data_err", r_data_err, 0);
        chk("post_zero", 32'(zero_count), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
